// File: rtl/galaksija_video_grabber.sv
// +----------------------------------------------------------------------+
// | galaksija_video_grabber: measures VGA timing, packs the 1-bpp window  |
// | into frame-buffer byte writes.               Rev 1.0                  |
// +----------------------------------------------------------------------+
`default_nettype none

module galaksija_video_grabber #(
  parameter int unsigned X_OFFSET   = 34,
  parameter int unsigned Y_OFFSET   = 15,
  parameter int unsigned CAP_WIDTH  = 256,
  parameter int unsigned CAP_HEIGHT = 207,
  parameter int unsigned ADDR_W     = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        vga_dat,
  input  logic              vga_hsync,
  input  logic              vga_vsync,
  input  logic              vga_blank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              locked,
  output logic              frame_done,
  output logic [9:0]        h_total_meas,
  output logic [9:0]        v_total_meas
);

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_MEASURE, S_LOCKED} state_t;
  localparam logic [9:0] SAT = 10'd1023;

  logic hs_q, vs_q, blank_q, pix_q, hs_p_q, vs_p_q, blank_p_q;
  logic w_hs_fall, w_vs_fall, w_blank_fall, w_blank_rise;
  logic [9:0] h_cnt_q, h_len_q, v_cnt_q, x_q, y_q, h_meas_q, v_meas_q;
  logic first_q;
  logic [9:0] w_h_len, w_v_len, w_y;
  logic [31:0] w_x32, w_y32, w_addr_full;
  logic w_in_win, w_cap, w_ok, w_match;
  logic [2:0] bit_q;
  logic [6:0] sr_q;
  logic wr_en_q, locked_q, frame_done_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0] wr_data_q;
  state_t state_q, state_d;
  logic store_d, fd_d;
  logic unused_ok;

  assign w_hs_fall    = hs_p_q & ~hs_q;
  assign w_vs_fall    = vs_p_q & ~vs_q;
  assign w_blank_fall = blank_p_q & ~blank_q;
  assign w_blank_rise = ~blank_p_q & blank_q;

  // Totals as seen this cycle, so a coincident hsync edge belongs to the ending frame
  assign w_h_len = w_hs_fall ? ((h_cnt_q == SAT) ? SAT : h_cnt_q + 10'd1) : h_len_q;
  assign w_v_len = (w_hs_fall && v_cnt_q != SAT) ? v_cnt_q + 10'd1 : v_cnt_q;
  assign w_y     = (w_blank_fall && !first_q && y_q != SAT) ? y_q + 10'd1 : y_q;

  assign w_x32    = {22'd0, x_q};
  assign w_y32    = {22'd0, w_y};
  assign w_in_win = !blank_q && w_x32 >= X_OFFSET && w_x32 < X_OFFSET + CAP_WIDTH
                    && w_y32 >= Y_OFFSET && w_y32 < Y_OFFSET + CAP_HEIGHT;
  assign w_cap    = enable && state_q == S_LOCKED && w_in_win;
  assign w_addr_full = (w_y32 - Y_OFFSET) * (CAP_WIDTH / 8) + ((w_x32 - X_OFFSET) >> 3);

  assign w_ok    = w_h_len != SAT && w_v_len != SAT && w_h_len >= 10'd8;
  assign w_match = w_h_len == h_meas_q && w_v_len == v_meas_q;

  always_comb begin
    state_d = state_q;
    store_d = 1'b0;
    fd_d    = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_SEEK;
        S_SEEK:  if (w_vs_fall) state_d = S_MEASURE;
        S_MEASURE: if (w_vs_fall) begin
          store_d = 1'b1;
          if (w_ok) state_d = S_LOCKED;
        end
        S_LOCKED: if (w_vs_fall) begin
          store_d = 1'b1;
          if (w_match) fd_d = 1'b1;
          else         state_d = S_MEASURE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q <= 1'b1; vs_q <= 1'b1; blank_q <= 1'b1; pix_q <= 1'b0;
      hs_p_q <= 1'b1; vs_p_q <= 1'b1; blank_p_q <= 1'b1;
      h_cnt_q <= '0; h_len_q <= '0; v_cnt_q <= '0;
      x_q <= '0; y_q <= '0; first_q <= 1'b1;
      h_meas_q <= '0; v_meas_q <= '0;
      bit_q <= '0; sr_q <= '0;
      wr_en_q <= 1'b0; wr_addr_q <= '0; wr_data_q <= '0;
      locked_q <= 1'b0; frame_done_q <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      hs_q <= vga_hsync; vs_q <= vga_vsync; blank_q <= vga_blank; pix_q <= vga_dat[7];
      hs_p_q <= hs_q; vs_p_q <= vs_q; blank_p_q <= blank_q;

      if (w_hs_fall) begin
        h_len_q <= w_h_len;
        h_cnt_q <= '0;
      end else if (h_cnt_q != SAT) begin
        h_cnt_q <= h_cnt_q + 10'd1;
      end

      if (w_vs_fall)                       v_cnt_q <= '0;
      else if (w_hs_fall && v_cnt_q != SAT) v_cnt_q <= v_cnt_q + 10'd1;

      if (w_blank_rise)                 x_q <= '0;
      else if (!blank_q && x_q != SAT)  x_q <= x_q + 10'd1;

      if (w_vs_fall) begin
        y_q     <= '0;
        first_q <= 1'b1;
      end else if (w_blank_fall) begin
        y_q     <= w_y;
        first_q <= 1'b0;
      end

      // Window rows are whole bytes, so restarting the bit count outside it keeps alignment
      if (w_cap) begin
        sr_q  <= {sr_q[5:0], pix_q};
        bit_q <= bit_q + 3'd1;
      end else begin
        bit_q <= '0;
      end
      wr_en_q <= w_cap && bit_q == 3'd7;
      if (w_cap && bit_q == 3'd7) begin
        wr_data_q <= {sr_q, pix_q};
        wr_addr_q <= w_addr_full[ADDR_W-1:0];
      end

      if (store_d) begin
        h_meas_q <= w_h_len;
        v_meas_q <= w_v_len;
      end
      state_q      <= state_d;
      locked_q     <= state_d == S_LOCKED;
      frame_done_q <= fd_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign locked       = locked_q;
  assign frame_done   = frame_done_q;
  assign h_total_meas = h_meas_q;
  assign v_total_meas = v_meas_q;

  assign unused_ok = ^{vga_dat[6:0], w_addr_full[31:ADDR_W]};

endmodule

`default_nettype wire

// File: tb/tb_galaksija_video_grabber.sv
// Bench for galaksija_video_grabber on a scaled-down generator raster
// (64 clk/line, 24 lines/frame) so every frame stays short.
`default_nettype none

module tb_galaksija_video_grabber;
  localparam int XO = 5, YO = 3, CW = 32, CH = 12, AW = 8;
  localparam int V_TOT = 24, H_ACT = 48, V_ACT = 18;

  logic clk = 1'b0;
  logic reset, enable, hs, vs, bl;
  logic [7:0] vga_dat;
  logic wr_en, locked, frame_done;
  logic [AW-1:0] wr_addr;
  logic [7:0] wr_data;
  logic [9:0] h_meas, v_meas;

  always #5 clk = ~clk;

  galaksija_video_grabber #(
    .X_OFFSET(XO), .Y_OFFSET(YO), .CAP_WIDTH(CW), .CAP_HEIGHT(CH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .vga_dat(vga_dat),
    .vga_hsync(hs), .vga_vsync(vs), .vga_blank(bl),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .locked(locked), .frame_done(frame_done),
    .h_total_meas(h_meas), .v_total_meas(v_meas)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [31:0]   cyc;
  } wr_t;

  wr_t exp_q[$];
  int cyc = 0;
  int checks = 0, passes = 0, fails = 0;
  int wr_cnt = 0, fd_cnt = 0;
  logic [AW-1:0] last_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (frame_done === 1'b1) fd_cnt++;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      last_addr = wr_addr;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 64'(wr_en), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr_data", 64'({wr_addr, wr_data}), 64'({e.addr, e.data}));
        chk("wr_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // One raster frame. Vsync falls at line 19 (h=0, or h=52 together with hsync when simul).
  task automatic frame(input int htot, input bit simul, input bit cap_in, input bit pat,
                       input bit lk0, input bit lk1, input bit fd,
                       input int rst_line, input int en_line);
    bit cap;
    logic [7:0] acc;
    logic pbit, vs_prev;
    int vs_c, wr0, fd0, exp_w;
    wr_t e;
    cap = cap_in; acc = '0; vs_c = -10; vs_prev = vs;
    wr0 = wr_cnt; fd0 = fd_cnt; exp_w = 0;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < htot; h++) begin
        @(negedge clk);
        if (cyc == vs_c + 1) begin
          chk("locked_vs+1", 64'(locked), 64'(lk0));
          chk("frame_done_vs+1", 64'(frame_done), 64'd0);
        end
        if (cyc == vs_c + 2) begin
          chk("locked_vs+2", 64'(locked), 64'(lk1));
          chk("frame_done_vs+2", 64'(frame_done), 64'(fd));
        end
        if (reset) reset = 1'b0;
        if (v == rst_line && h == 2) begin
          reset = 1'b1;
          #1;
          chk("reset_midstream", 64'({wr_en, wr_addr, wr_data, locked, frame_done, h_meas, v_meas}), 64'd0);
          exp_q.delete();
          cap = 1'b0;
        end
        if (v == en_line && h == XO + 12) begin
          enable = 1'b0;
          cap = 1'b0;
        end
        if (v == en_line && h == XO + 14) chk("locked_after_disable", 64'(locked), 64'd0);

        pbit = pat ? 1'($urandom_range(0, 1)) : !(v == YO && h == XO);
        hs = !(h >= 52 && h < 56);
        vs = simul ? !((v == 19 && h >= 52) || v == 20 || (v == 21 && h < 52))
                   : !(v == 19 || v == 20);
        bl = (h >= H_ACT) || (v >= V_ACT);
        vga_dat = {pbit, 7'($urandom)};
        if (vs_prev && !vs) vs_c = cyc;
        vs_prev = vs;

        if (cap && v >= YO && v < YO + CH && h >= XO && h < XO + CW) begin
          acc = {acc[6:0], pbit};
          if ((h - XO) % 8 == 7) begin
            e.addr = AW'((v - YO) * (CW / 8) + (h - XO) / 8);
            e.data = acc;
            e.cyc  = 32'(cyc + 2);
            exp_q.push_back(e);
            exp_w++;
          end
        end
      end
    end
    chk("frame_writes", 64'(wr_cnt - wr0), 64'(exp_w));
    chk("frame_done_count", 64'(fd_cnt - fd0), 64'(fd));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; vga_dat = '0; hs = 1'b1; vs = 1'b1; bl = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({wr_en, wr_addr, wr_data, locked, frame_done, h_meas, v_meas}), 64'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Acquire lock on nominal timing
    frame(64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    frame(64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    chk("h_total_lock", 64'(h_meas), 64'd64);
    chk("v_total_lock", 64'(v_meas), 64'd24);
    frame(64, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, -1, -1);
    chk("last_addr", 64'(last_addr), 64'(CW / 8 * CH - 1));
    frame(64, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);

    // Line length grows by one clock
    frame(65, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);
    chk("h_total_changed", 64'(h_meas), 64'd65);
    frame(65, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
    chk("h_total_relock", 64'(h_meas), 64'd65);
    frame(65, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
    frame(64, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
    frame(64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    frame(64, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);

    // Enable dropped mid-byte, then full relock
    frame(64, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, 5);
    chk("h_total_held_idle", 64'(h_meas), 64'd64);
    chk("v_total_held_idle", 64'(v_meas), 64'd24);
    enable = 1'b1;
    frame(64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    frame(64, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    frame(64, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);

    // Mid-frame reset, then coincident hsync/vsync edges
    frame(64, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8, -1);
    frame(64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    chk("v_total_simul", 64'(v_meas), 64'd24);
    chk("h_total_simul", 64'(h_meas), 64'd64);
    frame(64, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, -1, -1);
    frame(64, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
    chk("locked_held_simul", 64'(locked), 64'd1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
